// File: rtl/cabac_mvd_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cabac_mvd_pkg : context indices and enums shared by the mvd/mvp SE generator
// Revision: 1.0
// ---------------------------------------------------------------------------
package cabac_mvd_pkg;

  localparam logic [8:0] CTX_MVD_GR0    = 9'h016;
  localparam logic [8:0] CTX_MVD_GR1    = 9'h017;
  localparam logic [8:0] CTX_MVD_MINUS2 = 9'h0be;
  localparam logic [8:0] CTX_MVD_SIGN   = 9'h0bb;
  localparam logic [8:0] CTX_MVP_FLAG   = 9'h0b0;

  localparam logic [3:0] SE_BIN_NUM     = 4'd1;
  localparam int         STEPS_PER_LIST = 9;

  typedef enum logic [3:0] {
    STEP_GR0_X    = 4'd0,
    STEP_GR0_Y    = 4'd1,
    STEP_GR1_X    = 4'd2,
    STEP_GR1_Y    = 4'd3,
    STEP_MINUS2_X = 4'd4,
    STEP_SIGN_X   = 4'd5,
    STEP_MINUS2_Y = 4'd6,
    STEP_SIGN_Y   = 4'd7,
    STEP_MVP      = 4'd8
  } mvd_step_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } mvd_state_e;

endpackage
`default_nettype wire

// File: rtl/cabac_mvd_comp_flags.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cabac_mvd_comp_flags : saturate one mvd component and derive its SE fields
// Revision: 1.0
// ---------------------------------------------------------------------------
module cabac_mvd_comp_flags #(
  parameter int MVD_W = 11,
  parameter int VAL_W = MVD_W - 1
) (
  input  logic [MVD_W-1:0] mvd,
  output logic             g0,
  output logic             g1,
  output logic             sign,
  output logic [VAL_W-1:0] minus2
);

  localparam logic [MVD_W-1:0] MOST_NEG = {1'b1, {(MVD_W-1){1'b0}}};
  localparam logic [MVD_W-1:0] ONE      = {{(MVD_W-1){1'b0}}, 1'b1};
  localparam logic [MVD_W-1:0] TWO      = {{(MVD_W-2){1'b0}}, 2'b10};

  logic [MVD_W-1:0] sat;
  logic [MVD_W-1:0] abs_v;

  // Folding the most negative code onto -(2^(W-1)-1) keeps abs within MVD_W-1 bits
  always_comb begin
    sat    = (mvd == MOST_NEG) ? (mvd + ONE) : mvd;
    sign   = mvd[MVD_W-1];
    abs_v  = sign ? (~sat + ONE) : sat;
    g0     = |abs_v;
    g1     = (abs_v > ONE);
    minus2 = VAL_W'(abs_v - TWO);
  end

endmodule
`default_nettype wire

// File: rtl/cabac_se_prepare_mvd_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cabac_se_prepare_mvd_seq : emits the required mvd/mvp SE pairs of one PU
// Revision: 1.0
// ---------------------------------------------------------------------------
module cabac_se_prepare_mvd_seq
  import cabac_mvd_pkg::*;
#(
  parameter int MVD_W = 11,
  parameter int VAL_W = MVD_W - 1,
  parameter int SE_W  = VAL_W + 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pu_valid_i,
  output logic               pu_ready_o,
  input  logic [1:0]         pu_dir_i,
  input  logic [2*MVD_W-1:0] mvd_l0_i,
  input  logic [2*MVD_W-1:0] mvd_l1_i,
  input  logic [2:0]         mvp_idx_l0_i,
  input  logic [2:0]         mvp_idx_l1_i,
  input  logic               mvd_l1_zero_i,
  output logic               se_valid_o,
  input  logic               se_ready_i,
  output logic [SE_W-1:0]    se_pair_o,
  output logic               se_last_o,
  output logic               pu_done_o
);

  localparam int NPOS = 2 * STEPS_PER_LIST;

  mvd_state_e state, next_state;

  logic [1:0]         dir_q;
  logic [2*MVD_W-1:0] mvd_l0_q, mvd_l1_q;
  logic [2:0]         idx_l0_q, idx_l1_q;
  logic               zero_q;
  logic [4:0]         cursor;

  logic               idle;
  logic [1:0]         src_dir;
  logic [2*MVD_W-1:0] src_l0, src_l1;
  logic [2:0]         src_idx0, src_idx1;
  logic               src_zero;

  logic [MVD_W-1:0]   comp_mvd [4];
  logic [3:0]         g0, g1, sgn;
  logic [VAL_W-1:0]   minus2 [4];

  logic [NPOS-1:0]    req;
  logic [4:0]         start_pos, load_pos, last_pos;
  logic               found;
  logic               load_l1;
  logic [3:0]         step_num;
  logic [1:0]         cx, cy;
  logic               mvp_nz;
  logic [VAL_W-1:0]   val;
  logic [8:0]         ctx;

  // While idle the raw inputs feed the datapath so the first pair loads on acceptance
  assign idle     = (state == ST_IDLE);
  assign src_dir  = idle ? pu_dir_i      : dir_q;
  assign src_l0   = idle ? mvd_l0_i      : mvd_l0_q;
  assign src_l1   = idle ? mvd_l1_i      : mvd_l1_q;
  assign src_idx0 = idle ? mvp_idx_l0_i  : idx_l0_q;
  assign src_idx1 = idle ? mvp_idx_l1_i  : idx_l1_q;
  assign src_zero = idle ? mvd_l1_zero_i : zero_q;

  assign comp_mvd[0] = src_l0[2*MVD_W-1:MVD_W];
  assign comp_mvd[1] = src_l0[MVD_W-1:0];
  assign comp_mvd[2] = src_l1[2*MVD_W-1:MVD_W];
  assign comp_mvd[3] = src_l1[MVD_W-1:0];

  for (genvar c = 0; c < 4; c++) begin : g_comp
    cabac_mvd_comp_flags #(
      .MVD_W (MVD_W),
      .VAL_W (VAL_W)
    ) u_flags (
      .mvd    (comp_mvd[c]),
      .g0     (g0[c]),
      .g1     (g1[c]),
      .sign   (sgn[c]),
      .minus2 (minus2[c])
    );
  end

  // Bit n of the result marks step n of one list as required
  function automatic logic [8:0] list_req(input logic used, input logic mvd_on,
                                          input logic g0x, input logic g0y,
                                          input logic g1x, input logic g1y);
    logic [8:0] r;
    r = {1'b1, {8{mvd_on}} & {g0y, g1y, g0x, g1x, g0y, g0x, 1'b1, 1'b1}};
    return used ? r : 9'd0;
  endfunction

  assign req = {list_req(src_dir[1], !(src_zero && (src_dir == 2'b11)), g0[2], g0[3], g1[2], g1[3]),
                list_req(src_dir[0], 1'b1, g0[0], g0[1], g1[0], g1[1])};

  always_comb begin
    start_pos = idle ? 5'd0 : cursor;
    found     = 1'b0;
    load_pos  = '0;
    last_pos  = '0;
    for (int p = 0; p < NPOS; p++) begin
      if (req[p] && !found && (5'(p) >= start_pos)) begin
        found    = 1'b1;
        load_pos = 5'(p);
      end
      if (req[p]) last_pos = 5'(p);
    end
  end

  always_comb begin
    load_l1  = (load_pos >= 5'(STEPS_PER_LIST));
    step_num = load_l1 ? 4'(load_pos - 5'(STEPS_PER_LIST)) : load_pos[3:0];
    cx       = load_l1 ? 2'd2 : 2'd0;
    cy       = load_l1 ? 2'd3 : 2'd1;
    mvp_nz   = load_l1 ? (|src_idx1) : (|src_idx0);
    val      = '0;
    ctx      = CTX_MVP_FLAG;
    case (mvd_step_e'(step_num))
      STEP_GR0_X:    begin val[0] = g0[cx];  ctx = CTX_MVD_GR0;    end
      STEP_GR0_Y:    begin val[0] = g0[cy];  ctx = CTX_MVD_GR0;    end
      STEP_GR1_X:    begin val[0] = g1[cx];  ctx = CTX_MVD_GR1;    end
      STEP_GR1_Y:    begin val[0] = g1[cy];  ctx = CTX_MVD_GR1;    end
      STEP_MINUS2_X: begin val = minus2[cx]; ctx = CTX_MVD_MINUS2; end
      STEP_SIGN_X:   begin val[0] = sgn[cx]; ctx = CTX_MVD_SIGN;   end
      STEP_MINUS2_Y: begin val = minus2[cy]; ctx = CTX_MVD_MINUS2; end
      STEP_SIGN_Y:   begin val[0] = sgn[cy]; ctx = CTX_MVD_SIGN;   end
      STEP_MVP:      begin val[0] = mvp_nz;  ctx = CTX_MVP_FLAG;   end
      default:       begin val = '0;         ctx = CTX_MVP_FLAG;   end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (pu_valid_i) next_state = (pu_dir_i == 2'b00) ? ST_DONE : ST_EMIT;
      ST_EMIT: if (se_valid_o && se_ready_i && se_last_o) next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  assign pu_ready_o = idle;
  assign pu_done_o  = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      se_valid_o <= 1'b0;
      se_pair_o  <= '0;
      se_last_o  <= 1'b0;
      cursor     <= '0;
      dir_q      <= '0;
      mvd_l0_q   <= '0;
      mvd_l1_q   <= '0;
      idx_l0_q   <= '0;
      idx_l1_q   <= '0;
      zero_q     <= 1'b0;
    end else begin
      if (idle && pu_valid_i) begin
        dir_q    <= pu_dir_i;
        mvd_l0_q <= mvd_l0_i;
        mvd_l1_q <= mvd_l1_i;
        idx_l0_q <= mvp_idx_l0_i;
        idx_l1_q <= mvp_idx_l1_i;
        zero_q   <= mvd_l1_zero_i;
      end
      // Output register refills on acceptance or on each transfer; nothing left means PU end
      if ((idle && pu_valid_i) || ((state == ST_EMIT) && se_valid_o && se_ready_i)) begin
        if (found) begin
          se_valid_o <= 1'b1;
          se_pair_o  <= {val, SE_BIN_NUM, ctx};
          se_last_o  <= (load_pos == last_pos);
          cursor     <= load_pos + 5'd1;
        end else begin
          se_valid_o <= 1'b0;
          se_last_o  <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/cabac_se_prepare_mvd_seq.md
Name: cabac_se_prepare_mvd_seq

Overview:
Sequential, parametrised mvd/mvp syntax-element (SE) generator for the CABAC front end. It accepts one PU's motion data for L0 and/or L1 over a valid/ready handshake. It emits only the SE pairs that HEVC requires, one per cycle, in bitstream order, to the SE-pair consumer (binarizer). It supports bi-prediction, mvd_l1_zero_flag suppression and saturation of out-of-range mvd input.

Parameters:
MVD_W, 11, signed mvd component width (two's complement).
VAL_W, MVD_W-1, SE value field width.
SE_W, VAL_W+13, SE pair width: {value[VAL_W], bin_num[4], ctx_idx[9]}.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
pu_valid_i  in  1  PU motion data valid
pu_ready_o  out  1  block idle, can accept a PU
pu_dir_i  in  2  bit0 = L0 used, bit1 = L1 used
mvd_l0_i  in  2*MVD_W  {mvd_x, mvd_y}, list 0
mvd_l1_i  in  2*MVD_W  {mvd_x, mvd_y}, list 1
mvp_idx_l0_i  in  3  mvp candidate index, list 0
mvp_idx_l1_i  in  3  mvp candidate index, list 1
mvd_l1_zero_i  in  1  slice mvd_l1_zero_flag
se_valid_o  out  1  se_pair_o valid
se_ready_i  in  1  consumer accepts pair
se_pair_o  out  SE_W  SE pair
se_last_o  out  1  final pair of current PU
pu_done_o  out  1  one-cycle pulse after the last pair handshakes

Behaviour:
- Reset: pu_ready_o=1; se_valid_o=0; se_pair_o=0; se_last_o=0; pu_done_o=0; FSM=IDLE. Reset mid-PU aborts the PU, discards the remaining SEs and takes no further handshakes.
- FSM states: IDLE, EMIT, DONE.
  - IDLE: pu_ready_o=1. On pu_valid_i&pu_ready_o, register all inputs and go to EMIT. If pu_dir_i==0, go to DONE directly with no pairs emitted.
  - EMIT: pu_ready_o=0. Walk per-list step counter 0..8, L0 first then L1.
  - DONE: pu_done_o=1 for one cycle, then IDLE.
- Latency: first se_valid_o is the cycle after acceptance. One pair is emitted per cycle while se_ready_i=1. Steps that are not required are skipped with zero bubble; the next required step is computed combinationally from the captured flags.
- A list is processed iff its pu_dir bit=1. L1's mvd steps 0-7 are skipped when mvd_l1_zero_i=1 and pu_dir_i==2'b11; its step 8 is still emitted.
- Saturation: a component equal to -2^(MVD_W-1) is treated as -(2^(MVD_W-1)-1). abs = |mvd|, MVD_W bits; minus2 = abs-2 truncated to VAL_W bits (no overflow after saturation).
- Steps per list, each gated by a condition (g0/g1 = greater0/greater1 of that component):
  - 0: gr0_x, always, {abs_x!=0, 1, 0x016}.
  - 1: gr0_y, always, {abs_y!=0, 1, 0x016}.
  - 2: gr1_x, if g0x, {abs_x>1, 1, 0x017}.
  - 3: gr1_y, if g0y, {abs_y>1, 1, 0x017}.
  - 4: minus2_x, if g1x, {minus2_x, 1, 0x0be}.
  - 5: sign_x, if g0x, {sign_x, 1, 0x0bb}.
  - 6: minus2_y, if g1y, {minus2_y, 1, 0x0be}.
  - 7: sign_y, if g0y, {sign_y, 1, 0x0bb}.
  - 8: mvp flag, always, {mvp_idx!=0, 1, 0x0b0}.
  - 1-bit values are zero-extended to VAL_W.
- Handshake: se_pair_o, se_valid_o and se_last_o are registered outputs. They are held stable while se_valid_o&!se_ready_i. A transfer occurs on se_valid_o&se_ready_i. se_valid_o never drops without a transfer.
- se_last_o=1 only with the last required pair of the PU.
- Back-to-back PUs: a new PU is accepted no earlier than the cycle after DONE, so at least a 2-cycle gap after the last transfer.

Decomposition:
- Package cabac_mvd_pkg: ctx constants CTX_MVD_GR0=0x016, CTX_MVD_GR1=0x017, CTX_MVD_MINUS2=0x0be, CTX_MVD_SIGN=0x0bb, CTX_MVP_FLAG=0x0b0; step enum (9 values); FSM state enum; SE bin_num constant 1.
- Sub-module cabac_mvd_comp_flags (combinational, one instance per component): saturate, abs, g0, g1, sign, minus2.

Test Plan:
- L0 only, mvd=(0,0), idx 0 -> 3 pairs: gr0x val0, gr0y val0, mvp val0 ctx 0x0b0 with last; then pu_done pulse.
- L0, mvd=(+5,-1), idx 1 -> gr0x1, gr0y1, gr1x1, gr1y0, minus2x=3 ctx 0x0be, signx0, signy1, mvp1 (8 pairs, no minus2_y).
- Bi, L1 mvd=(-3,0), mvd_l1_zero=1 -> L0 pairs, then L1 only mvp pair with last; L1 mvd ignored.
- MVD_W=11, mvd_x=-1024 -> saturates to abs 1023, minus2=1021, sign=1.
- Random se_ready_i stalls (ready low 3 cycles mid-PU) -> pair held stable, no loss or duplication, order as per step table.
- Reset asserted during step 4 -> next cycle se_valid_o=0, pu_ready_o=1; a fresh PU is emitted correctly.
